// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared types and sizing helpers for the FIFO UART drain stage
// Optional parity frame bit is enabled by FIFO_UART_TX_PARITY_EN.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int baud_cnt_w(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

    function automatic int bit_cnt_w(input int data_width);
        return $clog2(data_width + 1);
    endfunction

    function automatic int frame_len(input int data_width, input int stop_bits,
                                     input int clks_per_bit);
        return (1 + data_width + PARITY_BITS + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-time divider for the FIFO UART drain stage
// bit_tick marks the final rdclk cycle of each bit; the count is held at zero while idle.
module uart_baud_counter
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic rdclk,
    input  logic rdrst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int BW = baud_cnt_w(CLKS_PER_BIT);

    logic [BW-1:0] count_q;
    logic [BW-1:0] count_d;
    logic          wrap;

    assign wrap     = (count_q == BW'(CLKS_PER_BIT - 1));
    assign bit_tick = run && wrap;

    always_comb begin
        count_d = count_q;
        if (!run || wrap) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge rdclk or negedge rdrst_n) begin
        if (!rdrst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops FWFT FIFO words and serialises them as UART frames
// Even parity bit after the data bits when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  rdclk,
    input  logic                  rdrst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    input  logic                  tx_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BCW = bit_cnt_w(DATA_WIDTH);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif
    logic                  bit_tick;
    logic                  last_stop;
    logic                  pop;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .rdclk    (rdclk),
        .rdrst_n  (rdrst_n),
        .run      (busy_q),
        .bit_tick (bit_tick)
    );

    assign shift_nxt = shift_q >> 1;
    assign last_stop = (state_q == STOP) && bit_tick && (bit_cnt_q == BCW'(STOP_BITS - 1));

    // Gated by reset so the FIFO never sees a pop strobe while this block is held in reset.
    assign pop = rdrst_n && tx_enable && !fifo_empty && ((state_q == IDLE) || last_stop);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_d      = parity_q;
`else
                        state_d   = STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        shift_d   = shift_nxt;
                        tx_d      = shift_nxt[0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef FIFO_UART_TX_PARITY_EN
                if (bit_tick) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
`else
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
`endif
            end
            STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        state_d   = IDLE;
                        tx_d      = 1'b1;
                        busy_d    = 1'b0;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A pop from IDLE or from the final stop cycle launches the next frame with no gap.
        if (pop) begin
            state_d   = START;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            shift_d   = fifo_rdata;
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d  = ^fifo_rdata;
`endif
        end
    end

    always_ff @(posedge rdclk or negedge rdrst_n) begin
        if (!rdrst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign fifo_rd_en = pop;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = last_stop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed bench for fifo_uart_tx (CLKS_PER_BIT=4, STOP_BITS 1 and 2)
// Expects a parity bit per frame when built with FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CPB = 4;

    logic       rdclk;
    logic       rdrst_n;
    logic       tx_enable;
    logic       fifo_empty, fifo_empty2;
    logic [7:0] fifo_rdata, fifo_rdata2;
    logic       fifo_rd_en, fifo_rd_en2;
    logic       tx, tx2;
    logic       busy, busy2;
    logic       frame_done, frame_done2;

    int n_tests = 0;
    int n_fail  = 0;
    int pops1   = 0;
    int pops2   = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic pend1 = 1'b0;
    logic pend2 = 1'b0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
        .rdclk      (rdclk),
        .rdrst_n    (rdrst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .tx_enable  (tx_enable),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
        .rdclk      (rdclk),
        .rdrst_n    (rdrst_n),
        .fifo_empty (fifo_empty2),
        .fifo_rdata (fifo_rdata2),
        .fifo_rd_en (fifo_rd_en2),
        .tx_enable  (tx_enable),
        .tx         (tx2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    task automatic refresh();
        fifo_empty  = (q1.size() == 0);
        fifo_rdata  = (q1.size() == 0) ? 8'h00 : q1[0];
        fifo_empty2 = (q2.size() == 0);
        fifo_rdata2 = (q2.size() == 0) ? 8'h00 : q2[0];
    endtask

    // FWFT FIFO model: pop strobes sampled mid-cycle, head advances just after the edge.
    always @(negedge rdclk) begin
        pend1 = fifo_rd_en;
        pend2 = fifo_rd_en2;
    end

    always @(posedge rdclk) begin
        #1;
        if (pend1 && q1.size() > 0) begin
            void'(q1.pop_front());
            pops1++;
        end
        if (pend2 && q2.size() > 0) begin
            void'(q2.pop_front());
            pops2++;
        end
        pend1 = 1'b0;
        pend2 = 1'b0;
        refresh();
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] d);
        if (sel) q2.push_back(d);
        else     q1.push_back(d);
        refresh();
    endtask

    // Called at the sample point of the pop cycle; walks every cycle of the frame.
    task automatic watch_frame(input bit sel, input logic [7:0] d, input logic par,
                               input int sb, input logic exp_next_pop);
        int   nbits;
        logic exp_bit;
        logic last;
        logic [3:0] got;
        logic busy_bad, fd_bad, early, rd_last;
        logic s_tx, s_busy, s_fd, s_rd;
        nbits    = 1 + 8 + P + sb;
        busy_bad = 1'b0;
        fd_bad   = 1'b0;
        early    = 1'b0;
        rd_last  = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)                exp_bit = 1'b0;
            else if (b <= 8)           exp_bit = d[b-1];
            else if (P == 1 && b == 9) exp_bit = par;
            else                       exp_bit = 1'b1;
            for (int k = 0; k < CPB; k++) begin
                @(negedge rdclk);
                s_tx   = sel ? tx2 : tx;
                s_busy = sel ? busy2 : busy;
                s_fd   = sel ? frame_done2 : frame_done;
                s_rd   = sel ? fifo_rd_en2 : fifo_rd_en;
                got[k] = s_tx;
                last   = (b == nbits - 1) && (k == CPB - 1);
                if (s_busy !== 1'b1) busy_bad = 1'b1;
                if (s_fd !== last)   fd_bad   = 1'b1;
                if (!last && s_rd)   early    = 1'b1;
                if (last)            rd_last  = s_rd;
            end
            check($sformatf("tx_bit%0d_%02h", b, d), {28'd0, got}, {28'd0, {4{exp_bit}}});
        end
        check($sformatf("busy_held_%02h", d), {31'd0, busy_bad}, 32'd0);
        check($sformatf("frame_done_last_%02h", d), {31'd0, fd_bad}, 32'd0);
        check($sformatf("no_early_pop_%02h", d), {31'd0, early}, 32'd0);
        check($sformatf("pop_at_end_%02h", d), {31'd0, rd_last}, {31'd0, exp_next_pop});
    endtask

    typedef struct {
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic bad;
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h81, 1'b0};
        vecs[5] = '{8'h01, 1'b1};

        rdrst_n   = 1'b0;
        tx_enable = 1'b0;
        refresh();
        repeat (3) @(negedge rdclk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(posedge rdclk); #2;
        rdrst_n   = 1'b1;
        tx_enable = 1'b1;

        // Empty FIFO: no pops, line idle.
        bad = 1'b0;
        repeat (200) begin
            @(negedge rdclk);
            if (fifo_rd_en || fifo_rd_en2 || !tx || !tx2 || busy) bad = 1'b1;
        end
        check("empty_idle", {31'd0, bad}, 32'd0);

        // Single-frame vectors.
        for (int i = 0; i < 6; i++) begin
            @(posedge rdclk); #2;
            push(0, vecs[i].data);
            @(negedge rdclk);
            check($sformatf("pop_%02h", vecs[i].data), {31'd0, fifo_rd_en}, 32'd1);
            watch_frame(0, vecs[i].data, vecs[i].exp_par, 1, 1'b0);
            @(negedge rdclk);
            check($sformatf("idle_busy_%02h", vecs[i].data), {31'd0, busy}, 32'd0);
            check($sformatf("idle_tx_%02h", vecs[i].data), {31'd0, tx}, 32'd1);
        end
        check("pops_single", pops1, 32'd6);

        // Back-to-back frames.
        @(posedge rdclk); #2;
        push(0, 8'h3C);
        push(0, 8'hC3);
        @(negedge rdclk);
        check("b2b_pop1", {31'd0, fifo_rd_en}, 32'd1);
        watch_frame(0, 8'h3C, 1'b0, 1, 1'b1);
        watch_frame(0, 8'hC3, 1'b0, 1, 1'b0);
        check("pops_b2b", pops1, 32'd8);

        // tx_enable dropped at cycle 10: frame completes, no further pop.
        @(posedge rdclk); #2;
        push(0, 8'h55);
        push(0, 8'h11);
        @(negedge rdclk);
        check("dis_pop", {31'd0, fifo_rd_en}, 32'd1);
        fork
            watch_frame(0, 8'h55, 1'b0, 1, 1'b0);
            begin
                repeat (10) @(negedge rdclk);
                tx_enable = 1'b0;
            end
        join
        bad = 1'b0;
        repeat (20) begin
            @(negedge rdclk);
            if (fifo_rd_en || busy || !tx) bad = 1'b1;
        end
        check("dis_no_pop", {31'd0, bad}, 32'd0);
        check("dis_pops", pops1, 32'd9);
        @(posedge rdclk); #2;
        tx_enable = 1'b1;
        @(negedge rdclk);
        check("reen_pop", {31'd0, fifo_rd_en}, 32'd1);
        watch_frame(0, 8'h11, 1'b0, 1, 1'b0);

        // Reset at cycle 17 of a 0xF0 frame.
        @(posedge rdclk); #2;
        push(0, 8'hF0);
        push(0, 8'h2D);
        @(negedge rdclk);
        check("rstmid_pop", {31'd0, fifo_rd_en}, 32'd1);
        repeat (17) @(negedge rdclk);
        check("rstmid_pre_tx", {31'd0, tx}, 32'd0);
        rdrst_n = 1'b0;
        #1;
        check("rstmid_tx", {31'd0, tx}, 32'd1);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        repeat (3) @(negedge rdclk);
        @(posedge rdclk); #2;
        rdrst_n = 1'b1;
        @(negedge rdclk);
        check("rstmid_next_pop", {31'd0, fifo_rd_en}, 32'd1);
        watch_frame(0, 8'h2D, 1'b0, 1, 1'b0);
        check("pops_total", pops1, 32'd12);
        check("q1_drained", q1.size(), 32'd0);

        // Two stop bits.
        @(posedge rdclk); #2;
        push(1, 8'h81);
        push(1, 8'h42);
        @(negedge rdclk);
        check("sb2_pop1", {31'd0, fifo_rd_en2}, 32'd1);
        watch_frame(1, 8'h81, 1'b0, 2, 1'b1);
        watch_frame(1, 8'h42, 1'b0, 2, 1'b0);
        @(negedge rdclk);
        check("sb2_idle_busy", {31'd0, busy2}, 32'd0);
        check("sb2_pops", pops2, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
